// File: rtl/uart_tx_core.sv
// UART transmit serializer: a one-entry holding register feeds a start/data/parity/stop
// shifter. Every bit boundary is paced by the shared baud_tick strobe.
module uart_tx_core #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [7:0] DATA_MASK = 8'hFF >> (8 - DATA_BITS);
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       PAR_INV   = 1'(PARITY_ODD);

    state_t     state, state_next;
    logic [7:0] hold, shifter, hold_masked;
    logic       hold_full, par_bit, stop_cnt;
    logic [2:0] bit_cnt;
    logic       last_data, last_stop, load, tx_next, done_next;

    assign hold_masked = hold & DATA_MASK;
    assign last_data   = (bit_cnt == LAST_BIT);
    assign last_stop   = (stop_cnt == LAST_STOP);
    assign tx_ready    = !hold_full;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (baud_tick) begin
            case (state)
                IDLE:    if (hold_full) state_next = START;
                START:   state_next = DATA;
                DATA:    if (last_data) state_next = (PARITY_EN != 0) ? PARITY : STOP;
                PARITY:  state_next = STOP;
                STOP:    if (last_stop) state_next = hold_full ? START : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // tx is registered, so this computes the level the line takes after the edge.
    always_comb begin
        tx_next   = tx;
        done_next = 1'b0;
        load      = 1'b0;
        if (baud_tick) begin
            done_next = (state == STOP) && last_stop;
            load      = hold_full && ((state == IDLE) || done_next);
            case (state_next)
                START:   tx_next = 1'b0;
                DATA:    tx_next = (state == START) ? shifter[0] : shifter[1];
                PARITY:  tx_next = par_bit;
                default: tx_next = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx        <= 1'b1;
            tx_done   <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            shifter   <= '0;
            par_bit   <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
        end else begin
            tx      <= tx_next;
            tx_done <= done_next;
            // load needs hold_full, so an accept can never coincide with a frame start.
            if (load) begin
                shifter   <= hold_masked;
                par_bit   <= (^hold_masked) ^ PAR_INV;
                hold_full <= 1'b0;
            end else if (tx_valid && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end
            if (baud_tick && state == START) begin
                bit_cnt <= '0;
            end else if (baud_tick && state == DATA && !last_data) begin
                bit_cnt <= bit_cnt + 3'd1;
                shifter <= shifter >> 1;
            end
            if (baud_tick && state != STOP && state_next == STOP)
                stop_cnt <= 1'b0;
            else if (baud_tick && state == STOP && !last_stop)
                stop_cnt <= stop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_tx_core.sv
// Bench for uart_tx_core: five parameter variants driven side by side, checked every cycle
// against a frame-level line model, plus hand-derived frame vectors and reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_core;
    localparam int NI = 5;
    // variants: 0=8N1, 1=8E1, 2=8O1, 3=8N2, 4=5 data bits odd parity 2 stop
    localparam bit [NI-1:0][3:0] DBV = {4'd5, 4'd8, 4'd8, 4'd8, 4'd8};
    localparam bit [NI-1:0]      PEV = 5'b10110;
    localparam bit [NI-1:0]      POV = 5'b10100;
    localparam bit [NI-1:0][1:0] SBV = {2'd2, 2'd2, 2'd1, 2'd1, 2'd1};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick = 1'b0;
    logic [NI-1:0] tv = '0;
    logic [NI-1:0] tr, txo, bz, dn;
    logic [7:0]    td [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        uart_tx_core #(
            .DATA_BITS(int'(DBV[g])), .PARITY_EN(int'(PEV[g])),
            .PARITY_ODD(int'(POV[g])), .STOP_BITS(int'(SBV[g]))
        ) u_dut (
            .clk(clk), .rst(rst), .baud_tick(tick), .tx_valid(tv[g]), .tx_data(td[g]),
            .tx_ready(tr[g]), .tx(txo[g]), .busy(bz[g]), .tx_done(dn[g])
        );
    end

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // driver state
    logic [7:0] sendq [NI][$];
    bit         acc [NI];
    bit         tick_en = 0, gap_rnd = 0, t_was;
    int         div = 3, tcnt = 0;
    // capture of one instance's line at each tick edge
    int         capg = 0, ntick = 0, ndone = 0;
    string      cap;
    // line model: the frame in flight as a bit list plus the one-byte holding slot
    int         pos [NI], flen [NI];
    bit         infr [NI], slot [NI];
    logic [7:0] slotv [NI];
    logic [11:0] fb [NI];
    logic       m_tx [NI], m_done [NI];

    typedef struct {
        int         g;
        logic [7:0] d0;
        logic [7:0] d1;
        bit         two;
        string      bits;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(string name, int g, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d @%0t: got %b expected %b", name, g, $time, act, exp);
        end
    endtask

    task automatic chk_i(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_s(string name, string act, string exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s @%0t: got %s expected %s", name, $time, act, exp);
        end
    endtask

    // Full frame as the list of line levels, one per bit period.
    function automatic int build(int g, logic [7:0] d, output logic [11:0] b);
        int   n;
        logic p;
        b = '1;
        b[0] = 1'b0;
        p = POV[g];
        n = 1;
        for (int i = 0; i < int'(DBV[g]); i++) begin
            b[n] = d[i];
            p ^= d[i];
            n++;
        end
        if (PEV[g]) begin
            b[n] = p;
            n++;
        end
        return n + int'(SBV[g]);
    endfunction

    task automatic model_step();
        for (int g = 0; g < NI; g++) begin
            bit slot_pre;
            slot_pre = slot[g];
            if (rst) begin
                infr[g] = 0; slot[g] = 0; pos[g] = 0; m_tx[g] = 1'b1; m_done[g] = 1'b0;
            end else begin
                m_done[g] = 1'b0;
                if (tick) begin
                    if (infr[g] && pos[g] < flen[g]) begin
                        m_tx[g] = fb[g][pos[g]];
                        pos[g]++;
                    end else begin
                        if (infr[g]) m_done[g] = 1'b1;
                        infr[g] = 0;
                        m_tx[g] = 1'b1;
                        if (slot[g]) begin
                            flen[g] = build(g, slotv[g], fb[g]);
                            slot[g] = 0;
                            infr[g] = 1;
                            m_tx[g] = fb[g][0];
                            pos[g] = 1;
                        end
                    end
                end
                if (tv[g] && !slot_pre) begin
                    slot[g] = 1;
                    slotv[g] = td[g];
                end
            end
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < NI; g++) begin
            chk("tx", g, txo[g], m_tx[g]);
            chk("tx_ready", g, tr[g], logic'(!slot[g]));
            chk("busy", g, bz[g], logic'(infr[g]));
            chk("tx_done", g, dn[g], m_done[g]);
        end
    endtask

    task automatic drive();
        for (int g = 0; g < NI; g++) begin
            if (acc[g]) begin
                void'(sendq[g].pop_front());
                tv[g] = 1'b0;
            end
            if (!tv[g]) begin
                td[g] = 8'($urandom);
                if (sendq[g].size() > 0 && (!gap_rnd || $urandom_range(3) != 0)) begin
                    tv[g] = 1'b1;
                    td[g] = sendq[g][0];
                end
            end
        end
        tick = 1'b0;
        if (tick_en) begin
            tcnt++;
            if (tcnt >= div) begin
                tcnt = 0;
                tick = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        for (int g = 0; g < NI; g++) acc[g] = tv[g] && tr[g] && !rst;
        @(posedge clk);
        model_step();
        t_was = tick && !rst;
        @(negedge clk);
        check_all();
        if (t_was) begin
            if (txo[capg]) cap = {cap, "1"};
            else           cap = {cap, "0"};
            ntick++;
        end
        if (dn[capg]) ndone++;
        drive();
    endtask

    task automatic do_reset();
        for (int g = 0; g < NI; g++) sendq[g].delete();
        tv = '0;
        tick_en = 0;
        tick = 1'b0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        tcnt = 0;
    endtask

    function automatic bit activity();
        bit a;
        a = (tv != '0);
        for (int g = 0; g < NI; g++) a |= (sendq[g].size() > 0) || infr[g] || slot[g];
        return a;
    endfunction

    task automatic add(int g, logic [7:0] d0, logic [7:0] d1, bit two, string bits);
        vec_t v;
        v.g = g; v.d0 = d0; v.d1 = d1; v.two = two; v.bits = bits;
        tbl.push_back(v);
    endtask

    initial begin
        int cyc;
        for (int g = 0; g < NI; g++) begin
            td[g] = '0; pos[g] = 0; flen[g] = 0; infr[g] = 0; slot[g] = 0;
            m_tx[g] = 1'b1; m_done[g] = 1'b0; acc[g] = 0;
        end
        // line levels per tick, start bit first; each frame is followed by one idle-high tick
        add(0, 8'hA5, 8'h00, 0, "0101001011");
        add(0, 8'h00, 8'h00, 0, "0000000001");
        add(0, 8'hFF, 8'h00, 0, "0111111111");
        add(0, 8'h3C, 8'hC3, 1, "00011110010110000111");
        add(1, 8'h07, 8'h00, 0, "01110000011");
        add(2, 8'h07, 8'h00, 0, "01110000001");
        add(3, 8'h00, 8'h00, 0, "00000000011");
        add(3, 8'h00, 8'h00, 1, "0000000001100000000011");
        add(4, 8'hFF, 8'h00, 0, "011111011");
        add(4, 8'hE0, 8'h00, 0, "000000111");
        add(1, 8'h80, 8'h01, 1, "0000000011101000000011");

        // idle after reset: 20 ticks, nothing offered
        do_reset();
        chk("rst_tx", 0, txo[0], 1'b1);
        chk("rst_ready", 0, tr[0], 1'b1);
        tick_en = 1; div = 3; ntick = 0; cyc = 0;
        while (ntick < 20 && cyc < 200) begin
            cycle();
            chk("idle_tx", 0, txo[0], 1'b1);
            chk("idle_busy", 0, bz[0], 1'b0);
            chk("idle_ready", 0, tr[0], 1'b1);
            chk("idle_done", 0, dn[0], 1'b0);
            cyc++;
        end
        chk_i("idle_ticks", ntick, 20);

        // table of hand-derived frames
        for (int i = 0; i < tbl.size(); i++) begin
            do_reset();
            capg = tbl[i].g;
            gap_rnd = 0;
            sendq[tbl[i].g].push_back(tbl[i].d0);
            if (tbl[i].two) sendq[tbl[i].g].push_back(tbl[i].d1);
            repeat (4) cycle();
            cap = ""; ntick = 0; ndone = 0; tcnt = 0;
            div = $urandom_range(2, 5);
            tick_en = 1;
            cyc = 0;
            while (ntick < tbl[i].bits.len() + 1 && cyc < 600) begin
                cycle();
                cyc++;
            end
            chk_s($sformatf("frame%0d", i), cap, {tbl[i].bits, "1"});
            chk_i($sformatf("done_cnt%0d", i), ndone, tbl[i].two ? 2 : 1);
        end

        // reset on the 4th tick of a frame while a second byte is held
        do_reset();
        capg = 0; gap_rnd = 0;
        sendq[0].push_back(8'h5A);
        sendq[0].push_back(8'hC3);
        repeat (3) cycle();
        tick_en = 1; div = 4; tcnt = 0; ntick = 0; cyc = 0;
        while (ntick < 3 && cyc < 100) begin
            cycle();
            cyc++;
        end
        cyc = 0;
        while (!tick && cyc < 20) begin
            cycle();
            cyc++;
        end
        chk("held_pre_rst", 0, tr[0], 1'b0);
        chk("busy_pre_rst", 0, bz[0], 1'b1);
        sendq[0].delete();
        tv = '0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_tx", 0, txo[0], 1'b1);
        chk("mid_rst_ready", 0, tr[0], 1'b1);
        chk("mid_rst_busy", 0, bz[0], 1'b0);
        chk("mid_rst_done", 0, dn[0], 1'b0);
        ntick = 0; ndone = 0; cyc = 0;
        while (ntick < 20 && cyc < 200) begin
            cycle();
            chk("post_rst_tx", 0, txo[0], 1'b1);
            cyc++;
        end
        chk_i("post_rst_done", ndone, 0);

        // randomized traffic on all variants, with occasional mid-run resets
        for (int it = 0; it < 40; it++) begin
            int rst_at;
            div = $urandom_range(2, 6);
            tick_en = 1; gap_rnd = 1;
            for (int g = 0; g < NI; g++)
                repeat ($urandom_range(0, 3)) sendq[g].push_back(8'($urandom));
            rst_at = (it % 8 == 7) ? int'($urandom_range(10, 150)) : -1;
            cyc = 0;
            while (activity() && cyc < 5000) begin
                if (cyc == rst_at) begin
                    for (int g = 0; g < NI; g++) sendq[g].delete();
                    tv = '0;
                    rst = 1'b1;
                    cycle();
                    rst = 1'b0;
                end else begin
                    cycle();
                end
                cyc++;
            end
            chk_i($sformatf("drain%0d", it), int'(cyc < 5000), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
